uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter for the PWM generator's serial link: accepts bytes over a valid/ready write port into a 32-byte FIFO and serialises them on `tx_out` at 115200 baud, 8N1, LSB first. It is the transmit counterpart of the `uart_rx` receive path and shares its clock, baud and framing parameters. It reports status and end-of-string responses back to the host.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 115200: line rate. `BAUD_DIV = CLK_FREQ / BAUD_RATE` (integer division), giving 434 at the defaults.
- `TX_BUFFER_DEPTH`, default 32: FIFO depth in bytes. Must be a power of two, at least 2.
- `clk_50mhz`  input  1: system clock. All logic is on its rising edge.
- `rst`  input  1: reset, synchronous and active-high.
- `tx_data`  input  8: byte to enqueue.
- `tx_valid`  input  1: `tx_data` is valid this cycle.
- `tx_ready`  output  1: FIFO can accept a byte. Equals `!buffer_full`.
- `tx_out`  output  1: serial line, registered. Idles high.
- `tx_busy`  output  1: a frame is being shifted out (FSM not in IDLE).
- `buffer_empty`  output  1: FIFO count is 0.
- `buffer_full`  output  1: FIFO count is `TX_BUFFER_DEPTH`.
- `eos_sent`  output  1: one-cycle pulse when the stop bit of a 0x0D or 0x0A byte completes.

## Operation
- One clock domain, and every output is a register or a direct copy of one.
- While `rst` is high, the following hold at the next edge:
  - `tx_out`=1, `tx_ready`=1, `tx_busy`=0, `buffer_empty`=1, `buffer_full`=0, `eos_sent`=0.
  - FIFO pointers and count are 0, the FSM is in IDLE, and the baud counter is 0.
- A reset mid-frame aborts the frame. `tx_out` returns high at the next edge, and the in-flight byte and all queued bytes are discarded.
- FIFO:
  - A push happens on an edge where `tx_valid && tx_ready`. A push while full is impossible because `tx_ready`=0; that byte is ignored and the FIFO is unchanged.
  - Write and read pointers are `$clog2(TX_BUFFER_DEPTH)` bits and wrap modulo depth. The count is one bit wider.
  - Push and pop on the same edge leave the count unchanged. A pop when empty never occurs.
- The FSM has four states: IDLE, START, DATA, STOP.
  - IDLE: `tx_out`=1. If `!buffer_empty`, pop the head byte into the shift register, clear the baud counter, set `tx_out`=0 and go to START.
  - START: hold `tx_out`=0 for `BAUD_DIV` cycles, then go to DATA with bit index 0.
  - DATA: drive `tx_out` = shift[0] for `BAUD_DIV` cycles, then shift right and increment the bit index. After the bit at index 7, go to STOP.
  - STOP: hold `tx_out`=1 for `BAUD_DIV` cycles. On the final cycle:
    - if the transmitted byte is 0x0D or 0x0A, pulse `eos_sent`;
    - if the FIFO is non-empty, pop the next byte and go directly to START with no idle gap;
    - otherwise go to IDLE.
- Baud counter:
  - Counts 0 to `BAUD_DIV-1`, only while not in IDLE.
  - Every bit phase ends when the counter equals `BAUD_DIV-1`; the counter then wraps to 0.
  - The counter has `$clog2(BAUD_DIV)` bits.
- `tx_busy` = (state != IDLE). It stays 1 across back-to-back frames.

## Timing
- Accepting edge E:
  - `buffer_empty` falls after E.
  - At E+1 the FSM pops and `tx_out` falls, so start-bit-to-first-edge latency is 1 cycle after acceptance.
  - `tx_busy` rises at E+1.
- Frame length is exactly `10 × BAUD_DIV` cycles (4340 at the defaults). Each bit is exactly `BAUD_DIV` cycles, with no accumulated drift.
- For a queued successor, the next start bit begins on the cycle immediately after the last stop-bit cycle.
- `eos_sent` is high for exactly one cycle, coincident with the last stop-bit cycle of that frame.
- `buffer_full` and `tx_ready` update on the edge of the push or pop that changes the count, and are visible in the following cycle.
- Pop and push on the same edge with count `TX_BUFFER_DEPTH-1`: the count stays `TX_BUFFER_DEPTH-1` and `tx_ready` stays 1.

## Test plan
- **Single byte.** Push 0x55 into an idle block. Required: after 1 cycle `tx_out` goes low; the line then reads 0, 1,0,1,0,1,0,1,0, 1, with each level held 434 cycles; `tx_busy` lasts 4340 cycles; `eos_sent` stays 0.
- **Back-to-back.** Push 0x41, 0x42, 0x43 on 3 consecutive cycles. Required: three frames totalling 13020 cycles with no idle high between the stop and start bits; `tx_busy` stays high throughout; `buffer_empty` is 1 after the third pop.
- **Overflow.** Hold `tx_valid` for 40 cycles with incrementing data 0x00–0x27 while the first frame is in START. Required: 33 bytes accepted (1 popped plus 32 queued); `buffer_full`=1 and `tx_ready`=0; bytes 0x21–0x27 are dropped; the transmitted sequence is 0x00–0x20.
- **End of string.** Push 0x0D, then 0x0A. Required: `eos_sent` pulses for one cycle at the end of each stop bit, 4340 cycles apart.
- **Reset mid-frame.** Assert `rst` for 1 cycle during DATA bit 3 with 5 bytes queued. Required: `tx_out`=1, `tx_busy`=0, `buffer_empty`=1 and `tx_ready`=1 on the next cycle; no further frames follow.
- **Pointer wrap.** Push and transmit 70 bytes in batches of 20. Required: the received order matches the pushed order exactly, across two pointer wraps.

Source files
------------

// File: rtl/uart_tx.sv
`timescale 1ns / 1ps
// Byte-wide UART transmitter: a 32-entry FIFO feeds an 8N1, LSB-first serialiser.
// Successive queued bytes are sent back-to-back, and CR/LF bytes raise eos_sent.
module uart_tx #(
  parameter int CLK_FREQ        = 50_000_000,
  parameter int BAUD_RATE       = 115200,
  parameter int TX_BUFFER_DEPTH = 32
) (
  input  logic       clk_50mhz,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       buffer_empty,
  output logic       buffer_full,
  output logic       eos_sent
);
  // state | meaning
  // IDLE  | line high, waiting for a queued byte
  // START | start bit (low) for one bit period
  // DATA  | eight data bits, LSB first
  // STOP  | stop bit (high); chains straight into START if more bytes are queued

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int AW       = $clog2(TX_BUFFER_DEPTH);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BAUD_PRE  = CW'(BAUD_DIV - 2);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(TX_BUFFER_DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [TX_BUFFER_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg, cur_byte;
  logic          push, pop, bit_end, is_eos;

  assign tx_ready = ~buffer_full;
  assign push     = tx_valid & ~buffer_full;
  assign bit_end  = (baud_cnt == BAUD_LAST);
  assign pop      = ~buffer_empty & ((state == IDLE) | ((state == STOP) & bit_end));
  assign is_eos   = (cur_byte == 8'h0D) | (cur_byte == 8'h0A);

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk_50mhz) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      buffer_empty <= 1'b1;
      buffer_full  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count        <= count_next;
      buffer_empty <= (count_next == '0);
      buffer_full  <= (count_next == DEPTH_CNT);
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      cur_byte  <= '0;
      tx_out    <= 1'b1;
      tx_busy   <= 1'b0;
      eos_sent  <= 1'b0;
    end else begin
      // Registered pulse lands on the final stop-bit cycle, so set it one cycle early.
      eos_sent <= (state == STOP) && (baud_cnt == BAUD_PRE) && is_eos;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (pop) begin
            shift_reg <= mem[rd_ptr];
            cur_byte  <= mem[rd_ptr];
            tx_out    <= 1'b0;
            tx_busy   <= 1'b1;
            state     <= START;
          end else begin
            tx_out <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_out   <= shift_reg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            shift_reg <= {1'b0, shift_reg[7:1]};
            if (bit_idx == 3'd7) begin
              tx_out <= 1'b1;
              state  <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_out  <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (pop) begin
              shift_reg <= mem[rd_ptr];
              cur_byte  <= mem[rd_ptr];
              tx_out    <= 1'b0;
              state     <= START;
            end else begin
              tx_out  <= 1'b1;
              tx_busy <= 1'b0;
              state   <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
        default: begin
          state   <= IDLE;
          tx_out  <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
`timescale 1ns / 1ps
// Directed bench for uart_tx: a line monitor decodes every frame into a queue,
// and the tests compare decoded frames and status flags with hand-derived values.
module tb_uart_tx;
  localparam int CLK_FREQ  = 4_200_000;
  localparam int BAUD_RATE = 100_000;
  localparam int BD        = CLK_FREQ / BAUD_RATE;  // 42 cycles per bit
  localparam int FRAME     = 10 * BD;
  localparam int DEPTH     = 32;

  logic       clk_50mhz = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_out, tx_busy, buffer_empty, buffer_full, eos_sent;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int mon_aborts = 0;

  typedef struct {
    logic [7:0] b;
    int         start_cyc;
    int         eos_pos;
    int         bad;
  } frame_t;
  frame_t frames[$];

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_byte;
    int         exp_eos;
  } vec_t;
  vec_t vecs[8];

  uart_tx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD_RATE(BAUD_RATE),
    .TX_BUFFER_DEPTH(DEPTH)
  ) dut (
    .clk_50mhz(clk_50mhz),
    .rst(rst),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_out(tx_out),
    .tx_busy(tx_busy),
    .buffer_empty(buffer_empty),
    .buffer_full(buffer_full),
    .eos_sent(eos_sent)
  );

  always #5 clk_50mhz = ~clk_50mhz;
  always @(posedge clk_50mhz) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_frames(input int n, input int limit);
    int k = 0;
    while (frames.size() < n && k < limit) begin
      @(negedge clk_50mhz);
      k++;
    end
  endtask

  task automatic wait_until_cyc(input int target);
    while (cyc < target) @(negedge clk_50mhz);
  endtask

  task automatic expect_frame(input string name, input logic [7:0] exp_b, input int exp_eos,
                              output int sc);
    frame_t f;
    sc = -1;
    if (frames.size() == 0) begin
      tests++;
      failed++;
      $display("FAIL %s_missing: got no frame, expected byte 0x%02h", name, exp_b);
    end else begin
      f = frames.pop_front();
      sc = f.start_cyc;
      check({name, "_shape"}, 32'(f.bad), 32'd0);
      check({name, "_byte"}, 32'(f.b), 32'(exp_b));
      check({name, "_eos"}, 32'(f.eos_pos), 32'(exp_eos));
    end
  endtask

  // Line monitor: decodes each frame, checking every bit holds for exactly BD cycles.
  initial begin : monitor
    frame_t     f;
    logic [9:0] lvl;
    logic [3:0] bi;
    logic       pending, aborted;
    pending = 1'b0;
    forever begin
      if (!pending) @(negedge clk_50mhz);
      pending = 1'b0;
      if (tx_out === 1'b0 && tx_busy === 1'b1) begin
        f.start_cyc = cyc;
        f.bad = 0;
        f.eos_pos = -1;
        f.b = 8'h00;
        aborted = 1'b0;
        lvl = '0;
        for (int i = 0; i < FRAME; i++) begin
          if (i > 0) @(negedge clk_50mhz);
          if (tx_busy !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          bi = 4'(i / BD);
          if (i % BD == 0) lvl[bi] = tx_out;
          else if (tx_out !== lvl[bi]) f.bad |= 1;
          if (eos_sent === 1'b1) begin
            if (f.eos_pos < 0) f.eos_pos = i;
            else f.bad |= 2;
          end
        end
        if (aborted) begin
          mon_aborts++;
        end else begin
          if (lvl[0] !== 1'b0 || lvl[9] !== 1'b1) f.bad |= 1;
          f.b = lvl[8:1];
          @(negedge clk_50mhz);
          if (tx_out === 1'b1 && tx_busy !== 1'b0) f.bad |= 4;
          if (eos_sent !== 1'b0) f.bad |= 8;
          frames.push_back(f);
          pending = (tx_out === 1'b0);
        end
      end
    end
  end

  initial begin : stim
    int         sc0, sc1, sc2, s0, ab0, bad_idle, idx;
    logic [7:0] p;

    vecs[0] = '{8'h55, 8'h55, -1};
    vecs[1] = '{8'h00, 8'h00, -1};
    vecs[2] = '{8'hFF, 8'hFF, -1};
    vecs[3] = '{8'h0D, 8'h0D, FRAME - 1};
    vecs[4] = '{8'h0A, 8'h0A, FRAME - 1};
    vecs[5] = '{8'h80, 8'h80, -1};
    vecs[6] = '{8'h01, 8'h01, -1};
    vecs[7] = '{8'h0C, 8'h0C, -1};

    // Reset values: {tx_out, tx_ready, tx_busy, buffer_empty, buffer_full, eos_sent}
    repeat (3) @(negedge clk_50mhz);
    check("reset_state", 32'({tx_out, tx_ready, tx_busy, buffer_empty, buffer_full, eos_sent}),
          32'b110100);
    rst = 1'b0;
    @(negedge clk_50mhz);

    // Single-byte frames with one-cycle start latency
    foreach (vecs[v]) begin
      tx_valid = 1'b1;
      tx_data = vecs[v].data;
      @(negedge clk_50mhz);
      tx_valid = 1'b0;
      check("accept_tx_out_empty_busy", 32'({tx_out, buffer_empty, tx_busy}), 32'b100);
      @(negedge clk_50mhz);
      check("start_bit_latency", 32'({tx_out, tx_busy}), 32'b01);
      wait_frames(1, FRAME + 10);
      expect_frame("single", vecs[v].exp_byte, vecs[v].exp_eos, sc0);
      repeat (2) @(negedge clk_50mhz);
      check("single_idle", 32'({tx_out, tx_busy, buffer_empty}), 32'b101);
    end

    // Back-to-back: three frames with no idle gap
    for (int i = 0; i < 3; i++) begin
      tx_valid = 1'b1;
      tx_data = 8'h41 + 8'(i);
      @(negedge clk_50mhz);
    end
    tx_valid = 1'b0;
    wait_frames(3, 4 * FRAME);
    expect_frame("b2b0", 8'h41, -1, sc0);
    expect_frame("b2b1", 8'h42, -1, sc1);
    expect_frame("b2b2", 8'h43, -1, sc2);
    check("b2b_gap01", 32'(sc1 - sc0), 32'(FRAME));
    check("b2b_gap12", 32'(sc2 - sc1), 32'(FRAME));
    repeat (2) @(negedge clk_50mhz);
    check("b2b_end", 32'({tx_busy, buffer_empty}), 32'b01);
    check("b2b_aborts", 32'(mon_aborts), 32'd0);

    // Overflow: 40 pushes during the first start bit, 33 accepted
    s0 = 0;
    for (int i = 0; i < 40; i++) begin
      tx_valid = 1'b1;
      tx_data = 8'(i);
      @(negedge clk_50mhz);
      if (i == 0) s0 = cyc + 1;
    end
    tx_valid = 1'b0;
    check("ovf_full_ready", 32'({buffer_full, tx_ready}), 32'b10);
    wait_until_cyc(s0 + 2 * FRAME - 1);
    check("ovf_ready_at_31", 32'({tx_ready, buffer_full}), 32'b10);
    tx_valid = 1'b1;
    tx_data = 8'h99;
    @(negedge clk_50mhz);
    tx_valid = 1'b0;
    check("push_pop_at_31", 32'({tx_ready, buffer_full}), 32'b10);
    wait_frames(34, 36 * FRAME);
    sc1 = -1;
    for (int i = 0; i < 34; i++) begin
      p = (i < 33) ? 8'(i) : 8'h99;
      expect_frame("ovf", p, (p == 8'h0D || p == 8'h0A) ? FRAME - 1 : -1, sc0);
      if (i == 0) check("ovf_first_start", 32'(sc0), 32'(s0));
      else check("ovf_gap", 32'(sc0 - sc1), 32'(FRAME));
      sc1 = sc0;
    end
    repeat (2) @(negedge clk_50mhz);
    check("ovf_drained", 32'({tx_busy, buffer_empty, frames.size() == 0}), 32'b011);

    // End of string: CR then LF, pulses one frame apart
    tx_valid = 1'b1;
    tx_data = 8'h0D;
    @(negedge clk_50mhz);
    tx_data = 8'h0A;
    @(negedge clk_50mhz);
    tx_valid = 1'b0;
    wait_frames(2, 3 * FRAME);
    expect_frame("eos_cr", 8'h0D, FRAME - 1, sc0);
    expect_frame("eos_lf", 8'h0A, FRAME - 1, sc1);
    check("eos_spacing", 32'(sc1 - sc0), 32'(FRAME));
    repeat (2) @(negedge clk_50mhz);

    // Reset during data bit 3 with five bytes queued
    ab0 = mon_aborts;
    s0 = 0;
    for (int i = 0; i < 6; i++) begin
      tx_valid = 1'b1;
      tx_data = 8'hA8 + 8'(i);
      @(negedge clk_50mhz);
      if (i == 0) s0 = cyc + 1;
    end
    tx_valid = 1'b0;
    wait_until_cyc(s0 + 4 * BD + BD / 2);
    check("rst_in_bit3", 32'({tx_out, tx_busy}), 32'b11);
    rst = 1'b1;
    @(negedge clk_50mhz);
    rst = 1'b0;
    check("rst_mid_frame", 32'({tx_out, tx_busy, buffer_empty, tx_ready, buffer_full, eos_sent}),
          32'b101100);
    bad_idle = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk_50mhz);
      if (tx_out !== 1'b1 || tx_busy !== 1'b0 || buffer_empty !== 1'b1) bad_idle++;
    end
    check("rst_stays_idle", 32'(bad_idle), 32'd0);
    check("rst_no_frames", 32'(frames.size()), 32'd0);
    check("rst_abort_seen", 32'(mon_aborts), 32'(ab0 + 1));

    // Pointer wrap: 70 bytes in batches of 20
    idx = 0;
    for (int batch = 0; batch < 4; batch++) begin
      int n;
      n = (batch < 3) ? 20 : 10;
      for (int i = 0; i < n; i++) begin
        tx_valid = 1'b1;
        tx_data = 8'((idx + i) * 37 + 11);
        @(negedge clk_50mhz);
      end
      tx_valid = 1'b0;
      wait_frames(n, (n + 1) * FRAME);
      for (int i = 0; i < n; i++) begin
        p = 8'(idx * 37 + 11);
        expect_frame("wrap", p, (p == 8'h0D || p == 8'h0A) ? FRAME - 1 : -1, sc0);
        idx++;
      end
      repeat (2) @(negedge clk_50mhz);
    end
    check("wrap_end", 32'({tx_out, tx_busy, buffer_empty}), 32'b101);
    check("wrap_aborts", 32'(mon_aborts), 32'(ab0 + 1));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
